// File: rtl/reg_bus_pkg.sv
// Shared types for the register bus: microcode phases, register selectors
// and post-write pointer adjust codes.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    CYCLE_NONE      = 2'd0,
    CYCLE_REG_FETCH = 2'd1,
    CYCLE_REG_WRITE = 2'd2
  } microcode_cycle;

  typedef enum logic [3:0] {
    REG_A   = 4'd0,
    REG_B   = 4'd1,
    REG_XL  = 4'd2,
    REG_XH  = 4'd3,
    REG_XP  = 4'd4,
    REG_YL  = 4'd5,
    REG_YH  = 4'd6,
    REG_YP  = 4'd7,
    REG_SPL = 4'd8,
    REG_SPH = 4'd9,
    REG_ALU = 4'd10,
    REG_IMM = 4'd11,
    REG_MX  = 4'd12,
    REG_MY  = 4'd13
  } reg_type;

  typedef enum logic [2:0] {
    REG_NONE = 3'd0,
    INC_X    = 3'd1,
    INC_Y    = 3'd2,
    SP_INC   = 3'd3,
    SP_DEC   = 3'd4
  } reg_inc_type;

  // Memory-indirect selectors address memory through X or Y.
  function automatic logic is_mem_reg(input reg_type r);
    return (r == REG_MX) || (r == REG_MY);
  endfunction

endpackage

// File: rtl/reg_pointer_inc.sv
// 8-bit pointer adjust: +1 for X/Y/SP increments, -1 for SP decrement.
module reg_pointer_inc
  import reg_bus_pkg::*;
(
  input  logic [7:0]  value_in,
  input  reg_inc_type inc_sel,
  output logic [7:0]  value_out
);

  // Wrapping add/subtract selected by the adjust code.
  always_comb begin
    value_out = value_in;
    case (inc_sel)
      INC_X, INC_Y, SP_INC: value_out = value_in + 8'd1;
      SP_DEC:               value_out = value_in - 8'd1;
      default:              value_out = value_in;
    endcase
  end

endmodule

// File: rtl/reg_bus.sv
// Nibble register bus: a FETCH cycle latches a source value (or arms a
// memory read), the following WRITE cycle moves it to the destination,
// optionally adjusting the X, Y or SP pointer afterwards.
module reg_bus
  import reg_bus_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  microcode_cycle current_cycle,
  input  reg_type        bus_input_selector,
  input  reg_type        bus_output_selector,
  input  reg_inc_type    increment_selector,
  input  logic [3:0]     alu_result,
  input  logic [3:0]     immediate,
  input  logic [3:0]     mem_read_data,
  output logic [3:0]     bus_value,
  output logic [3:0]     a,
  output logic [3:0]     b,
  output logic [11:0]    x,
  output logic [11:0]    y,
  output logic [7:0]     sp,
  output logic [11:0]    mem_addr,
  output logic           mem_read,
  output logic           mem_write,
  output logic [3:0]     mem_write_data,
  output logic           illegal
);

  logic [3:0]  a_r, b_r, bus_value_r, latch_r;
  logic [11:0] x_r, y_r;
  logic [7:0]  sp_r;
  logic        latch_mem_r, fetched_r;

  logic        is_fetch_s, is_write_s, wr_ok_s;
  logic [3:0]  fetch_val_s, xfer_s;
  logic [3:0]  a_wr_s, b_wr_s;
  logic [11:0] x_wr_s, y_wr_s, x_nx_s, y_nx_s;
  logic [7:0]  sp_wr_s, sp_nx_s, ptr_in_s, ptr_out_s;

  // Strobes and the illegal pulse are suppressed while in reset.
  assign is_fetch_s = reset_n && (current_cycle == CYCLE_REG_FETCH);
  assign is_write_s = reset_n && (current_cycle == CYCLE_REG_WRITE);
  assign wr_ok_s    = is_write_s && fetched_r;
  assign xfer_s     = latch_mem_r ? mem_read_data : latch_r;

  // Source value mux for non-memory fetches.
  always_comb begin
    fetch_val_s = 4'h0;
    case (bus_input_selector)
      REG_A:   fetch_val_s = a_r;
      REG_B:   fetch_val_s = b_r;
      REG_XL:  fetch_val_s = x_r[3:0];
      REG_XH:  fetch_val_s = x_r[7:4];
      REG_XP:  fetch_val_s = x_r[11:8];
      REG_YL:  fetch_val_s = y_r[3:0];
      REG_YH:  fetch_val_s = y_r[7:4];
      REG_YP:  fetch_val_s = y_r[11:8];
      REG_SPL: fetch_val_s = sp_r[3:0];
      REG_SPH: fetch_val_s = sp_r[7:4];
      REG_ALU: fetch_val_s = alu_result;
      REG_IMM: fetch_val_s = immediate;
      default: fetch_val_s = 4'h0;
    endcase
  end

  // Register file contents after the destination write, before any adjust.
  always_comb begin
    a_wr_s  = a_r;
    b_wr_s  = b_r;
    x_wr_s  = x_r;
    y_wr_s  = y_r;
    sp_wr_s = sp_r;
    if (wr_ok_s) begin
      case (bus_output_selector)
        REG_A:   a_wr_s        = xfer_s;
        REG_B:   b_wr_s        = xfer_s;
        REG_XL:  x_wr_s[3:0]   = xfer_s;
        REG_XH:  x_wr_s[7:4]   = xfer_s;
        REG_XP:  x_wr_s[11:8]  = xfer_s;
        REG_YL:  y_wr_s[3:0]   = xfer_s;
        REG_YH:  y_wr_s[7:4]   = xfer_s;
        REG_YP:  y_wr_s[11:8]  = xfer_s;
        REG_SPL: sp_wr_s[3:0]  = xfer_s;
        REG_SPH: sp_wr_s[7:4]  = xfer_s;
        default: a_wr_s        = a_r;
      endcase
    end else begin
      a_wr_s = a_r;
    end
  end

  // Pick which 8-bit pointer feeds the adjuster.
  always_comb begin
    ptr_in_s = 8'h00;
    case (increment_selector)
      INC_X:          ptr_in_s = x_wr_s[7:0];
      INC_Y:          ptr_in_s = y_wr_s[7:0];
      SP_INC, SP_DEC: ptr_in_s = sp_wr_s;
      default:        ptr_in_s = 8'h00;
    endcase
  end

  reg_pointer_inc u_ptr (
    .value_in  (ptr_in_s),
    .inc_sel   (increment_selector),
    .value_out (ptr_out_s)
  );

  // Apply the pointer adjust only on a completed write; page nibbles are kept.
  always_comb begin
    x_nx_s  = x_wr_s;
    y_nx_s  = y_wr_s;
    sp_nx_s = sp_wr_s;
    if (wr_ok_s) begin
      case (increment_selector)
        INC_X:          x_nx_s  = {x_wr_s[11:8], ptr_out_s};
        INC_Y:          y_nx_s  = {y_wr_s[11:8], ptr_out_s};
        SP_INC, SP_DEC: sp_nx_s = ptr_out_s;
        default:        sp_nx_s = sp_wr_s;
      endcase
    end else begin
      sp_nx_s = sp_wr_s;
    end
  end

  // Memory strobes, address and write data; read and write are exclusive by phase.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = 12'h000;
    mem_write_data = 4'h0;
    if (is_fetch_s && is_mem_reg(bus_input_selector)) begin
      mem_read = 1'b1;
      mem_addr = (bus_input_selector == REG_MX) ? x_r : y_r;
    end else if (wr_ok_s && is_mem_reg(bus_output_selector)) begin
      mem_write      = 1'b1;
      mem_addr       = (bus_output_selector == REG_MX) ? x_r : y_r;
      mem_write_data = xfer_s;
    end else begin
      mem_addr = 12'h000;
    end
  end

  assign illegal = is_write_s && !fetched_r;

  // Bus latch, fetched flag and architectural registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r         <= 4'h0;
      b_r         <= 4'h0;
      x_r         <= 12'h000;
      y_r         <= 12'h000;
      sp_r        <= 8'h00;
      bus_value_r <= 4'h0;
      latch_r     <= 4'h0;
      latch_mem_r <= 1'b0;
      fetched_r   <= 1'b0;
    end else begin
      a_r  <= a_wr_s;
      b_r  <= b_wr_s;
      x_r  <= x_nx_s;
      y_r  <= y_nx_s;
      sp_r <= sp_nx_s;
      case (current_cycle)
        CYCLE_REG_FETCH: begin
          fetched_r <= 1'b1;
          if (is_mem_reg(bus_input_selector)) begin
            latch_mem_r <= 1'b1;
          end else begin
            latch_mem_r <= 1'b0;
            latch_r     <= fetch_val_s;
          end
        end
        CYCLE_REG_WRITE: begin
          fetched_r <= 1'b0;
          if (fetched_r) begin
            bus_value_r <= xfer_s;
          end
        end
        default: fetched_r <= 1'b0;
      endcase
    end
  end

  assign a         = a_r;
  assign b         = b_r;
  assign x         = x_r;
  assign y         = y_r;
  assign sp        = sp_r;
  assign bus_value = bus_value_r;

endmodule
